// File: rtl/argmax_stream.sv
// argmax_stream: terminal classification stage. Consumes M signed T-bit values per vector
// over a valid/ready handshake and emits a single beat holding the maximum value and the
// zero-based position of its first occurrence.
module argmax_stream #(
  parameter int M = 10,
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [T-1:0]         input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [T-1:0]         output_data,
  output logic [$clog2(M)-1:0] output_index
);

  localparam int LOGM = $clog2(M);
  localparam logic [LOGM-1:0] LAST_IDX = LOGM'(M - 1);

  typedef enum logic {
    S_IN  = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [LOGM-1:0]        cnt_reg;
  logic signed [T-1:0]    best_val_reg;
  logic [LOGM-1:0]        best_idx_reg;

  // Handshake flags follow the state; reset forces both low in the same cycle so no
  // transfer can be advertised while the block is being cleared.
  assign input_ready  = (state_reg == S_IN)  && !reset;
  assign output_valid = (state_reg == S_OUT) && !reset;

  // Result is presented straight from the running-best registers.
  assign output_data  = best_val_reg;
  assign output_index = best_idx_reg;

  // Collect one vector, tracking the running maximum, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IN;
      cnt_reg      <= '0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
    end else begin
      case (state_reg)
        S_IN: begin
          if (input_valid) begin
            // First element seeds the best unconditionally; later ones must be strictly
            // greater, so ties keep the earliest position.
            if (cnt_reg == '0) begin
              best_val_reg <= $signed(input_data);
              best_idx_reg <= '0;
            end else if ($signed(input_data) > best_val_reg) begin
              best_val_reg <= $signed(input_data);
              best_idx_reg <= cnt_reg;
            end
            if (cnt_reg == LAST_IDX) begin
              cnt_reg   <= '0;
              state_reg <= S_OUT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        S_OUT: begin
          // Upstream is stalled here; only the downstream acceptance moves us on.
          if (output_ready) begin
            state_reg <= S_IN;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= S_IN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
